// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC front-end chain.
// - framer_state_t : state encoding of the audio framer FSM
// - Q15_ONE/HALF   : Q1.15 unity and rounding constants
// - sat_add()      : signed add clamped to a given bit width, reused by
//                    later stages (window, FFT scaling)
package mfcc_pkg;

    typedef enum logic [2:0] {
        FILL,
        START,
        SERVE,
        WAIT_DONE,
        ADVANCE
    } framer_state_t;

    localparam int Q15_ONE  = 32768;
    localparam int Q15_HALF = 16384;

    // Adds two signed values and clamps the sum to the signed range of
    // 'width' bits. The sum is formed in 64 bits so it can never wrap
    // before clamping; callers truncate the result to 'width'.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int                 width
    );
        longint sum;
        longint max_v;
        longint min_v;
        sum   = longint'(a) + longint'(b);
        max_v = (longint'(1) << (width - 1)) - longint'(1);
        min_v = -max_v - longint'(1);
        if (sum > max_v) begin
            sum = max_v;
        end else if (sum < min_v) begin
            sum = min_v;
        end
        return 32'(sum);
    endfunction

endpackage

// File: rtl/framer_ram.sv
// Simple dual-port sample buffer for the audio framer.
// - clk      : clock
// - wr_en    : write wr_data to mem[wr_addr]
// - rd_en    : load mem[rd_addr] into the output register
// - rd_data  : registered read data, valid the cycle after rd_en
// Contents are never reset so the array maps onto block RAM.
module framer_ram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/audio_framer.sv
// Framing buffer at the head of the MFCC chain. Pre-emphasises a PCM
// stream into a circular buffer, announces each full frame with start_o
// and serves it one sample per rd_en_i to the window stage, then slides
// forward by HOP_LEN when the window stage reports frame_done_i.
// Ports:
// - clk, rst_n          : clock, asynchronous active-low reset
// - sample_i/_valid_i   : signed PCM input, no backpressure
// - start_o             : one-cycle pulse, a frame is ready
// - rd_en_i             : read request from the window stage
// - valid_to_read_o     : frame_sample_o valid (1 cycle after rd_en_i)
// - frame_sample_o      : frame sample, in order
// - frame_done_i        : window stage finished the current frame
// - busy_o              : high whenever the FSM is not in FILL
// - overflow_o          : sticky, an input sample was dropped
// - clear_ovf_i         : clears overflow_o (a same-cycle drop wins)
module audio_framer
    import mfcc_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAME_LEN    = 306,
    parameter int HOP_LEN      = 128,
    parameter int BUF_DEPTH    = 512,
    parameter int PREEMPH_EN   = 1,
    parameter int PREEMPH_COEF = 31785
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                           sample_valid_i,
    output logic                           start_o,
    input  logic                           rd_en_i,
    output logic                           valid_to_read_o,
    output logic signed [SAMPLE_WIDTH-1:0] frame_sample_o,
    input  logic                           frame_done_i,
    output logic                           busy_o,
    output logic                           overflow_o,
    input  logic                           clear_ovf_i
);

    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int AVAIL_W   = PTR_W + 1;
    localparam int RDC_W     = $clog2(FRAME_LEN + 1);
    localparam int PROD_W    = 2 * SAMPLE_WIDTH;
    localparam int Q15_SHIFT = $clog2(Q15_ONE);

    localparam logic [AVAIL_W-1:0] DEPTH_A = AVAIL_W'(BUF_DEPTH);
    localparam logic [AVAIL_W-1:0] FRAME_A = AVAIL_W'(FRAME_LEN);
    localparam logic [AVAIL_W-1:0] HOP_A   = AVAIL_W'(HOP_LEN);
    localparam logic [PTR_W-1:0]   HOP_P   = PTR_W'(HOP_LEN);
    localparam logic [RDC_W-1:0]   FRAME_R = RDC_W'(FRAME_LEN);
    localparam logic signed [SAMPLE_WIDTH-1:0] COEF = SAMPLE_WIDTH'(PREEMPH_COEF);

    framer_state_t state_reg, state_next;

    logic [PTR_W-1:0]               wr_ptr_reg;
    logic [PTR_W-1:0]               frame_base_reg;
    logic [AVAIL_W-1:0]             avail_reg, avail_next;
    logic [RDC_W-1:0]               rd_cnt_reg, rd_cnt_next;
    logic signed [SAMPLE_WIDTH-1:0] x_prev_reg;
    logic                           ovf_reg;
    logic                           rd_valid_reg;

    logic                           accept;
    logic                           drop;
    logic                           rd_fire;
    logic                           advance;
    logic [PTR_W-1:0]               rd_addr;
    logic [SAMPLE_WIDTH-1:0]        ram_rd_data;

    logic signed [PROD_W-1:0]       prod_rnd;
    logic signed [SAMPLE_WIDTH-1:0] emph_term;
    logic signed [SAMPLE_WIDTH-1:0] emph_y;

    // y = sat(x - round(a * x_prev)); the arithmetic shift floors, so
    // adding one half beforehand rounds half-up.
    assign prod_rnd  = PROD_W'(COEF) * PROD_W'(x_prev_reg) + PROD_W'(Q15_HALF);
    assign emph_term = SAMPLE_WIDTH'(prod_rnd >>> Q15_SHIFT);
    assign emph_y    = (PREEMPH_EN != 0)
                     ? SAMPLE_WIDTH'(sat_add(32'(sample_i), -32'(emph_term), SAMPLE_WIDTH))
                     : sample_i;

    // avail counts samples from frame_base, so refusing writes at
    // BUF_DEPTH is what protects the frame currently being served.
    assign accept  = sample_valid_i && (avail_reg < DEPTH_A);
    assign drop    = sample_valid_i && !accept;
    assign rd_fire = (state_reg == SERVE) && rd_en_i && (rd_cnt_reg < FRAME_R);
    assign rd_addr = frame_base_reg + PTR_W'(rd_cnt_reg);

    framer_ram #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (SAMPLE_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr_reg),
        .wr_data (emph_y),
        .rd_en   (rd_fire),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        state_next  = state_reg;
        rd_cnt_next = rd_cnt_reg;
        start_o     = 1'b0;
        advance     = 1'b0;
        case (state_reg)
            FILL: begin
                if (avail_reg >= FRAME_A) begin
                    state_next = START;
                end
            end
            START: begin
                start_o     = 1'b1;
                rd_cnt_next = '0;
                state_next  = SERVE;
            end
            SERVE: begin
                if (rd_fire) begin
                    rd_cnt_next = rd_cnt_reg + RDC_W'(1);
                end
                // rd_cnt reaches FRAME_LEN in the cycle the last sample is
                // on the output, so leaving now never cuts off a valid.
                if (rd_cnt_reg == FRAME_R) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (frame_done_i) begin
                    state_next = ADVANCE;
                end
            end
            ADVANCE: begin
                advance    = 1'b1;
                state_next = FILL;
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    assign avail_next = avail_reg + AVAIL_W'(accept) - (advance ? HOP_A : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FILL;
            wr_ptr_reg     <= '0;
            frame_base_reg <= '0;
            avail_reg      <= '0;
            rd_cnt_reg     <= '0;
            x_prev_reg     <= '0;
            ovf_reg        <= 1'b0;
            rd_valid_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_cnt_reg   <= rd_cnt_next;
            avail_reg    <= avail_next;
            rd_valid_reg <= rd_fire;
            ovf_reg      <= (ovf_reg && !clear_ovf_i) || drop;
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                x_prev_reg <= sample_i;
            end
            if (advance) begin
                frame_base_reg <= frame_base_reg + HOP_P;
            end
        end
    end

    // The RAM output register is not reset, so gate the data to keep it
    // at zero whenever no sample is being delivered.
    assign valid_to_read_o = rd_valid_reg;
    assign frame_sample_o  = rd_valid_reg ? $signed(ram_rd_data) : '0;
    assign busy_o          = (state_reg != FILL);
    assign overflow_o      = ovf_reg;

endmodule
